// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter slice.
package ram_arb_pkg;

  localparam int DEF_NREQ = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner, wrapping.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N   = DEF_NREQ,
  parameter int IDW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           adv,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [IDW-1:0] ptr;
  logic           found;

  // Two passes: first the requesters above the last winner, then the wrap-around part.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(N - 1);
    end else if (adv) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/dual_ram_arbiter.sv
// Shares one write port and one 1-cycle-latency read port of a RAM among NREQ requesters.
module dual_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = 32,
  parameter int AW   = 12,
  parameter int IDW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               ram_wen,
  output logic [AW-1:0]      ram_w_addr,
  output logic [DW-1:0]      ram_w_data,
  output logic               ram_ren,
  output logic [AW-1:0]      ram_r_addr,
  input  logic [DW-1:0]      ram_r_data
);

  logic [NREQ-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic [IDW-1:0]  wr_idx, rd_idx;
  logic            vld_p1;
  logic [IDW-1:0]  rd_tag_p1;

  assign wr_cand = req_valid & req_we;
  assign rd_cand = req_valid & ~req_we;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_cand),
    .adv     (|wr_cand),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_cand),
    .adv     (|rd_cand),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  assign req_ready = wr_gnt | rd_gnt;
  assign ram_wen   = |wr_gnt;
  assign ram_ren   = |rd_gnt;

  // Address/data muxes drive zero when idle so the RAM never sees X.
  always_comb begin
    ram_w_addr = '0;
    ram_w_data = '0;
    ram_r_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ram_wen && (wr_idx == IDW'(i))) begin
        ram_w_addr = req_addr[i*AW +: AW];
        ram_w_data = req_wdata[i*DW +: DW];
      end
      if (ram_ren && (rd_idx == IDW'(i))) begin
        ram_r_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // ---- stage p0 -> p1: remember who owns the read data arriving next cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      rd_tag_p1 <= '0;
    end else begin
      vld_p1    <= ram_ren;
      rd_tag_p1 <= rd_idx;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = vld_p1 && (rd_tag_p1 == IDW'(i));
    end
  end

  assign rsp_data = ram_r_data;

endmodule

// File: doc/dual_ram_arbiter.md
Name: dual_ram_arbiter

Overview:
- Shares one dual_ram instance (one write port, one read port, 1-cycle registered read) among NREQ requesters, e.g. instruction fetch, load/store unit and debug module.
- Read and write ports are arbitrated independently, each by its own round-robin arbiter.
- Each read grant is tagged so the RAM's next-cycle data is steered back to the requester that issued it.
- Sits between the core/debug requesters and the RAM macro. It has no storage of its own beyond grant tags and arbiter pointers.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, data width.
- AW, 12, word address width; must match the RAM's AW.
- IDW, 3, width of the requester-index tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  word addresses, requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  write data, requester i at [i*DW +: DW].
- req_ready  out  NREQ  grant; a handshake completes when valid and ready are both high.
- rsp_valid  out  NREQ  one-cycle read-data strobe, one bit per requester.
- rsp_data  out  DW  read data, shared bus, qualified by rsp_valid.
- ram_wen  out  1  to RAM wen.
- ram_w_addr  out  AW  to RAM w_addr.
- ram_w_data  out  DW  to RAM w_data.
- ram_ren  out  1  to RAM ren.
- ram_r_addr  out  AW  to RAM r_addr.
- ram_r_data  in  DW  from RAM r_data.

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0.
  - rd_ptr = wr_ptr = NREQ-1, so requester 0 has highest priority on the first cycle after reset.
  - Pending-read tag register cleared.
- Requester rules:
  - A requester holds valid, we, addr and wdata stable until ready.
  - Only one outstanding transaction per requester per cycle.
- Write arbitration (combinational):
  - Candidate set = {i | req_valid[i] & req_we[i]}.
  - Winner = first candidate scanning from wr_ptr+1 upward, wrapping modulo NREQ.
  - req_ready[winner] = 1; ram_wen = 1; ram_w_addr and ram_w_data come from the winner.
  - wr_ptr <= winner on the next edge, and only if a grant occurred.
- Read arbitration:
  - Same scheme over {i | req_valid[i] & ~req_we[i]} using rd_ptr.
  - ram_ren = 1; ram_r_addr comes from the winner.
  - Registers: rd_pend <= 1, rd_tag <= winner; otherwise rd_pend <= 0.
- Read response:
  - In the cycle after a read handshake (latency exactly 1): rsp_valid[rd_tag] = rd_pend, rsp_data = ram_r_data.
  - rsp_valid is combinational from registered state.
  - No response back-pressure; the requester must accept the data.
- Idle outputs:
  - With no candidate, ram_wen/ram_ren = 0, and address/data outputs are 0 (no X).
- Simultaneous read and write:
  - The same requester cannot issue both.
  - Different requesters may be granted in the same cycle, one write and one read.
  - If the addresses are equal, the RAM's forwarding returns the newly written data; the arbiter adds nothing.
- Back-to-back reads:
  - One read grant per cycle is sustained.
  - rd_tag updates every cycle, so responses follow grants in order, one cycle later.
- Fairness:
  - A continuously requesting requester is granted within NREQ cycles on its port.
- Reset mid-operation:
  - Asserting rst clears rd_pend immediately (async), so a pending response is dropped and never delivered.
  - RAM contents are untouched.
- Unused requester bits (NREQ < 2**IDW) are never granted.

Decomposition:
- Package ram_arb_pkg: constant DEF_NREQ=2 and the tag width function clog2.
- One sub-module rr_arbiter (params N): inputs req[N] and adv; outputs gnt[N] one-hot and gnt_idx. It owns the pointer register and is instantiated twice, for read and for write.
- The top level handles muxing, tag register and response steering.

Test Plan:
- Reset, then req0 write addr=0x010 data=0xDEADBEEF alone -> same cycle ram_wen=1, req_ready[0]=1; next cycle req0 reads 0x010 -> rsp_valid[0]=1, rsp_data=0xDEADBEEF one cycle after grant.
- req0 and req1 both reading continuously (addrs 0x001 / 0x002 preloaded 0x11 / 0x22) -> grants alternate 0,1,0,1; rsp_valid alternates one cycle later with data 0x11, 0x22.
- Same cycle: req1 writes 0x020=0xCAFEF00D and req0 reads 0x020 -> both ready; next cycle rsp_valid[0]=1, rsp_data=0xCAFEF00D (forwarded).
- Both requesters writing continuously for 8 cycles -> exactly 4 grants each, alternating; no cycle with two writes.
- Read granted to req1, rst asserted before the next edge -> rsp_valid stays 0 throughout; after release, first contested grant goes to req0.
- NREQ=3, all three reading -> grant order 0,1,2,0; rsp_valid one-hot, matching that order delayed by one cycle.
